// File: rtl/data_mem_responder.sv
`timescale 1ns/1ps
// data_mem_responder: word-wide data memory at the far end of the
// MemRead/MemWrite interface. It accepts one load or store per transaction
// and holds it for LATENCY wait states. It then completes with a one-cycle
// Ready pulse, carrying either load data or an Error flag.
//
// Ports:
//   Clk        rising-edge clock
//   Reset      asynchronous, active-high reset
//   MemRead    load request
//   MemWrite   store request
//   Address    byte address (word aligned, below DEPTH*4)
//   WriteData  store data
//   ReadData   last successful load result (registered)
//   Ready      one-cycle completion pulse (registered)
//   Error      transaction rejected, qualified by Ready (registered)
//   Stall      combinational hold request to the core
module data_mem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        Error,
  output logic        Stall
);

  localparam int unsigned IW       = $clog2(DEPTH);
  localparam logic [3:0]  CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  localparam bit          ZERO_LAT = (LATENCY == 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic            rd_q;
  logic            wr_q;
  logic [IW-1:0]   idx_q;
  logic [31:0]     wdata_q;

  logic [31:0]     mem [DEPTH];

  logic            req_c;
  logic            bad_c;
  logic            ex_c;
  logic            ex_rd_c;
  logic            ex_wr_c;
  logic [IW-1:0]   ex_idx_c;
  logic [31:0]     ex_wdata_c;

  // Request decode and acceptance-time validity check on the live inputs
  assign req_c = MemRead | MemWrite;
  assign bad_c = (MemRead & MemWrite) | (|Address[1:0]) |
                 (Address[31:2] >= 30'(DEPTH));

  assign Stall = ((state == S_IDLE) && req_c) || (state == S_WAIT);

  // Select the operation executing at this edge. With zero latency it
  // comes straight from the inputs, otherwise from the latched copy.
  always_comb begin
    ex_c       = 1'b0;
    ex_rd_c    = MemRead;
    ex_wr_c    = MemWrite;
    ex_idx_c   = Address[IW+1:2];
    ex_wdata_c = WriteData;
    case (state)
      S_IDLE: ex_c = ZERO_LAT && req_c && !bad_c;
      S_WAIT: begin
        ex_c       = (cnt == 4'd0);
        ex_rd_c    = rd_q;
        ex_wr_c    = wr_q;
        ex_idx_c   = idx_q;
        ex_wdata_c = wdata_q;
      end
      default: ex_c = 1'b0;
    endcase
  end

  // Backing array. It has no reset, so its contents survive Reset. When
  // Reset hits during WAIT the state is already forced to IDLE, which
  // keeps ex_c low and suppresses the write.
  always_ff @(posedge Clk) begin
    if (ex_c && ex_wr_c) begin
      mem[ex_idx_c] <= ex_wdata_c;
    end
  end

  // Transaction FSM with registered completion outputs
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= 32'd0;
      ReadData <= 32'd0;
      Ready    <= 1'b0;
      Error    <= 1'b0;
    end else begin
      Ready <= 1'b0;
      Error <= 1'b0;
      if (ex_c && ex_rd_c) begin
        ReadData <= mem[ex_idx_c];
      end
      case (state)
        S_IDLE: begin
          if (req_c) begin
            rd_q    <= MemRead;
            wr_q    <= MemWrite;
            idx_q   <= Address[IW+1:2];
            wdata_q <= WriteData;
            if (bad_c) begin
              state <= S_DONE;
              Ready <= 1'b1;
              Error <= 1'b1;
            end else if (ZERO_LAT) begin
              state <= S_DONE;
              Ready <= 1'b1;
            end else begin
              state <= S_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state <= S_DONE;
            Ready <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
`timescale 1ns/1ps
module tb_data_mem_responder;

  logic        Clk = 1'b0;
  logic        Reset;

  // LATENCY=2 instance
  logic        MemRead, MemWrite;
  logic [31:0] Address, WriteData, ReadData;
  logic        Ready, Error, Stall;

  // LATENCY=0 instance
  logic        rd0, wr0;
  logic [31:0] addr0, wd0, rdata0;
  logic        rdy0, err0, stall0;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  data_mem_responder #(.DEPTH(256), .LATENCY(2)) u_dut (
    .Clk(Clk), .Reset(Reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Address(Address), .WriteData(WriteData), .ReadData(ReadData),
    .Ready(Ready), .Error(Error), .Stall(Stall)
  );

  data_mem_responder #(.DEPTH(256), .LATENCY(0)) u_dut0 (
    .Clk(Clk), .Reset(Reset), .MemRead(rd0), .MemWrite(wr0),
    .Address(addr0), .WriteData(wd0), .ReadData(rdata0),
    .Ready(rdy0), .Error(err0), .Stall(stall0)
  );

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transaction on the selected instance (sel=1: LATENCY=0).
  // n counts cycles from the accepting edge to Ready (bounded).
  task automatic txn(input bit sel, input logic rd, input logic wr,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input string tag, output int n,
                     output logic [31:0] rdata, output logic err);
    if (sel) begin rd0 = rd; wr0 = wr; addr0 = addr; wd0 = wd; end
    else begin MemRead = rd; MemWrite = wr; Address = addr; WriteData = wd; end
    #1;
    chk({tag, "_stall_req"}, 32'(sel ? stall0 : Stall), 32'd1);
    tick;
    if (sel) begin rd0 = 1'b0; wr0 = 1'b0; end
    else begin MemRead = 1'b0; MemWrite = 1'b0; end
    n = 1;
    while (!(sel ? rdy0 : Ready) && n < 20) begin
      chk({tag, "_stall_wait"}, 32'(sel ? stall0 : Stall), 32'd1);
      tick;
      n++;
    end
    rdata = sel ? rdata0 : ReadData;
    err   = sel ? err0 : Error;
    chk({tag, "_stall_done"}, 32'(sel ? stall0 : Stall), 32'd0);
    tick;
    chk({tag, "_ready_drop"}, 32'(sel ? rdy0 : Ready), 32'd0);
  endtask

  initial begin
    int          n;
    logic [31:0] rdata;
    logic        err;
    int          consec;
    logic        prev;

    Reset = 1'b1;
    MemRead = 1'b0; MemWrite = 1'b0; Address = '0; WriteData = '0;
    rd0 = 1'b0; wr0 = 1'b0; addr0 = '0; wd0 = '0;
    #12;
    chk("rst_readdata", ReadData, 32'd0);
    chk("rst_ready",    32'(Ready), 32'd0);
    chk("rst_error",    32'(Error), 32'd0);
    chk("rst_stall",    32'(Stall), 32'd0);
    Reset = 1'b0;
    tick;

    // Store then load, LATENCY=2
    txn(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "st10", n, rdata, err);
    chk("st10_lat", 32'(n), 32'd3);
    chk("st10_err", 32'(err), 32'd0);
    txn(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, "ld10", n, rdata, err);
    chk("ld10_lat",  32'(n), 32'd3);
    chk("ld10_data", rdata, 32'hDEADBEEF);
    chk("ld10_err",  32'(err), 32'd0);

    // LATENCY=0 instance
    txn(1'b1, 1'b0, 1'b1, 32'h10, 32'hCAFEF00D, "z_st", n, rdata, err);
    chk("z_st_lat", 32'(n), 32'd1);
    txn(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, "z_ld", n, rdata, err);
    chk("z_ld_lat",  32'(n), 32'd1);
    chk("z_ld_data", rdata, 32'hCAFEF00D);
    tick;
    chk("z_ld_hold", rdata0, 32'hCAFEF00D);

    // Address 0 is an ordinary location
    txn(1'b0, 1'b0, 1'b1, 32'h0, 32'h12345678, "st0", n, rdata, err);
    txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, "ld0", n, rdata, err);
    chk("ld0_data", rdata, 32'h12345678);

    // Misaligned store aliases word 4; must not write
    txn(1'b0, 1'b0, 1'b1, 32'h13, 32'h99, "mis", n, rdata, err);
    chk("mis_lat", 32'(n), 32'd1);
    chk("mis_err", 32'(err), 32'd1);
    chk("mis_rd_unch", rdata, 32'h12345678);
    // Out of range store aliases word 0; must not write
    txn(1'b0, 1'b0, 1'b1, 32'h400, 32'h77, "oor", n, rdata, err);
    chk("oor_lat", 32'(n), 32'd1);
    chk("oor_err", 32'(err), 32'd1);
    txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, "ld0b", n, rdata, err);
    chk("ld0b_data", rdata, 32'h12345678);
    // Read and write together
    txn(1'b0, 1'b1, 1'b1, 32'h10, 32'h55, "both", n, rdata, err);
    chk("both_lat", 32'(n), 32'd1);
    chk("both_err", 32'(err), 32'd1);
    txn(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, "ld10b", n, rdata, err);
    chk("ld10b_data", rdata, 32'hDEADBEEF);
    chk("ld10b_err",  32'(err), 32'd0);

    // WriteData changing during WAIT is ignored
    MemWrite = 1'b1; Address = 32'h30; WriteData = 32'h1;
    tick;
    MemWrite = 1'b0; WriteData = 32'h2;
    tick; tick;
    chk("chg_ready", 32'(Ready), 32'd1);
    tick;
    txn(1'b0, 1'b1, 1'b0, 32'h30, 32'h0, "ld30", n, rdata, err);
    chk("ld30_data", rdata, 32'h1);

    // Reset during WAIT discards the store
    txn(1'b0, 1'b0, 1'b1, 32'h20, 32'hAA, "st20", n, rdata, err);
    MemWrite = 1'b1; Address = 32'h20; WriteData = 32'h55;
    tick;
    MemWrite = 1'b0;
    chk("rw_stall_wait", 32'(Stall), 32'd1);
    #1 Reset = 1'b1;
    #1;
    chk("rw_readdata", ReadData, 32'd0);
    chk("rw_ready",    32'(Ready), 32'd0);
    chk("rw_error",    32'(Error), 32'd0);
    chk("rw_stall",    32'(Stall), 32'd0);
    #2 Reset = 1'b0;
    tick; tick;
    chk("rw_noready", 32'(Ready), 32'd0);
    txn(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, "ld20", n, rdata, err);
    chk("ld20_lat",  32'(n), 32'd3);
    chk("ld20_data", rdata, 32'hAA);

    // Held MemRead: one completion every LATENCY+2 cycles
    MemRead = 1'b1; Address = 32'h10;
    consec = 0;
    prev = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick;
      chk($sformatf("held_ready_%0d", i), 32'(Ready), 32'((i % 4) == 3));
      if (Ready) chk($sformatf("held_data_%0d", i), ReadData, 32'hDEADBEEF);
      if (Ready && prev) consec++;
      prev = Ready;
    end
    MemRead = 1'b0;
    chk("held_consec", 32'(consec), 32'd0);
    tick; tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder at the far end of the MemRead/MemWrite interface driven by generalControl.
- Accepts one word load or store per transaction from the datapath and holds it for a configurable number of wait states.
- Completes with a one-cycle Ready pulse plus read data or an error flag.
- Drives Stall so the processor holds PC and pipeline state until completion.

Parameters:
- DEPTH, 256, number of 32-bit words in the backing array; power of two, 4 to 4096.
- LATENCY, 2, wait cycles between acceptance and completion; 0 to 15.

Ports:
- Clk  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high reset
- MemRead  input  1  load request from control unit
- MemWrite  input  1  store request from control unit
- Address  input  32  byte address from ALU result
- WriteData  input  32  store data (rt register value)
- ReadData  output  32  load result; valid when Ready=1 and the completed op was a load
- Ready  output  1  one-cycle completion pulse
- Error  output  1  qualified by Ready; transaction rejected
- Stall  output  1  combinational; core must not advance

Behaviour:
- Reset (async, active-high): state=IDLE, ReadData=0, Ready=0, Error=0, wait counter=0. Array contents are not cleared. Reset during WAIT discards the transaction; no write occurs.
- Request: Req = MemRead | MemWrite.
- Stall = (state==IDLE & Req) | (state==WAIT).
- Ready and Error are registered and high only in DONE. Stall is low in DONE.
- FSM states: IDLE, WAIT, DONE.
- IDLE, Req=1: latch MemRead, MemWrite, Address, WriteData into internal registers.
  - Invalid request (see below): next state is DONE with Error=1.
  - Valid, LATENCY=0: next state is DONE.
  - Valid, LATENCY>0: next state is WAIT, counter loaded with LATENCY-1.
- IDLE, Req=0: remain in IDLE; all outputs hold.
- WAIT: counter decrements each cycle. When counter==0, the transaction executes at that edge and the next state is DONE.
- DONE: one cycle; next state is IDLE unconditionally. A request present during DONE is not accepted; it is accepted in the following IDLE cycle.
- Latency: Ready rises LATENCY+1 cycles after the accepting edge.
- Inputs are latched at acceptance. Changes during WAIT are ignored.
- Word index = latched Address[log2(DEPTH)+1:2].
- Invalid request, checked at acceptance; any of the following gives Error=1, no array access, ReadData unchanged, and DONE on the next cycle regardless of LATENCY:
  - MemRead and MemWrite both 1;
  - Address[1:0] != 0 (misaligned);
  - Address[31:2] >= DEPTH (out of range).
- Load: ReadData is updated with array[index] at the edge entering DONE. It holds that value until the next successful load completes. Stores and errors leave it unchanged.
- Store: array[index] is written with the latched WriteData at the edge entering DONE.
- Read-after-write: a load following a store to the same address returns the new data.
- Address 0 behaves as a normal location (no hardwired zero).
- Back-to-back transactions: a new request is accepted no sooner than the IDLE cycle after DONE. Maximum throughput is one transaction per LATENCY+2 cycles.

Test Plan:
1. Store, then load with LATENCY=2: MemWrite, Address=0x10, WriteData=0xDEADBEEF. Ready pulses 3 cycles after acceptance, Error=0, Stall high for 3 cycles. Then MemRead, Address=0x10: ReadData=0xDEADBEEF when Ready pulses.
2. LATENCY=0: MemRead at Address=0x10 gives Ready one cycle after acceptance, with Stall high only in the accept cycle. ReadData holds after MemRead drops.
3. Errors:
   - Address=0x13 gives Ready and Error after 1 cycle, no write.
   - Address=0x400 with DEPTH=256 gives Error.
   - MemRead=MemWrite=1 gives Error; a subsequent load of 0x10 still returns 0xDEADBEEF.
4. Mid-transaction input change: WriteData switches from 0x1 to 0x2 during WAIT. A later load shows 0x1.
5. Reset asserted in WAIT of a store of 0x55 to 0x20 (previous value 0xAA): outputs go to 0 immediately, state returns to IDLE, and a later load of 0x20 returns 0xAA.
6. Held request across DONE: MemRead held continuously gives Ready pulses every LATENCY+2 cycles, with Ready never high on two consecutive cycles.
